framebuffer_scanout: RTL and testbench
======================================

Name: framebuffer_scanout

Overview:
- Display-side consumer of the 160x120 QQVGA dual-port framebuffer.
- Generates 640x480@60 VGA timing on the pixel clock and issues framebuffer read addresses with 4x horizontal and vertical pixel replication.
- Captures the framebuffer's registered read data.
- Drives sync, data-enable and pixel outputs, all pipeline-aligned, to the DAC/pins.

Parameters:
- DATA_WIDTH, 1, pixel width; matches framebuffer data width.
- ADDR_WIDTH, 15, framebuffer address width.
- FB_WIDTH, 160, framebuffer pixels per line.
- FB_HEIGHT, 120, framebuffer lines.
- SCALE_SHIFT, 2, log2 of replication factor (640/160 = 480/120 = 4).
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in clocks.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines.

Ports:
- clock, input, 1, pixel clock (25.175 MHz); also the framebuffer read_clock.
- reset_n, input, 1, asynchronous active-low reset.
- fb_read_addr, output, ADDR_WIDTH, to framebuffer read_addr.
- fb_q, input, DATA_WIDTH, from framebuffer q; one-clock registered read latency.
- vga_hsync, output, 1, horizontal sync, active low.
- vga_vsync, output, 1, vertical sync, active low.
- vga_de, output, 1, high during visible 640x480 region.
- vga_pixel, output, DATA_WIDTH, pixel data; 0 when vga_de low.
- frame_start, output, 1, one-clock pulse coincident with first visible pixel (0,0) on the pins.

Behaviour:
- Reset is asynchronous, active low. Reset values:
  - h_count = 0, v_count = 0, line_base = 0, fb_read_addr = 0.
  - vga_hsync = 1, vga_vsync = 1, vga_de = 0, vga_pixel = 0, frame_start = 0.
  - All pipeline delay registers cleared to the inactive state (syncs 1, de 0).
- Counters (stage 0):
  - h_count runs 0..799 and wraps to 0.
  - v_count increments when h_count wraps, runs 0..524 and wraps to 0.
  - Counters are free-running; there is no enable.
- Decode on the counters:
  - active = (h < 640) && (v < 480).
  - hs_n = !(656 <= h < 752).
  - vs_n = !(490 <= v < 492).
- Address generation:
  - No multiplier. line_base holds (v >> SCALE_SHIFT) * FB_WIDTH.
  - On the last clock of a line (h = 799): if v < 479 and v[1:0] = 3, line_base += FB_WIDTH; if v = 524, line_base = 0. Otherwise line_base holds.
  - Stage 1: fb_read_addr <= line_base + (h >> SCALE_SHIFT) when active, else fb_read_addr <= line_base.
  - Reads issued during blanking are harmless.
  - Maximum address is 19199; it must never exceed FB_WIDTH*FB_HEIGHT-1.
- Pipeline alignment:
  - Counter state at clock n produces fb_read_addr at n+1 and fb_q at n+2.
  - Pins are registered at n+3.
  - active, hs_n and vs_n pass through a 3-stage delay so that every pin corresponds to the same (h,v).
  - vga_pixel <= active_d2 ? fb_q : 0.
- frame_start:
  - Asserted for exactly one clock, when the pins present (h=0, v=0).
  - Asserted again every 420000 clocks.
- Simultaneous wraps at h=799, v=524: both counters go to 0 and line_base goes to 0 in the same edge.
- Reset mid-frame:
  - All state returns to reset values immediately.
  - After release, the first pins-valid pixel (0,0) appears 3 clocks later with a frame_start pulse.
  - No partial sync pulse is emitted during reset.
- fb_q is ignored whenever active_d2 is low.

Decomposition:
- Package vga_timing_pkg holds:
  - Timing constants: H_ACTIVE, H_FP, H_SYNC, H_BP, H_TOTAL=800, V_ACTIVE, V_FP, V_SYNC, V_BP, V_TOTAL=525.
  - Derived sync start/end constants.
  - PIPE_LATENCY = 3.
- Sub-module vga_timing_counter: h/v counters plus active/hs_n/vs_n decode. This sub-module is reused by the planned writer-side vblank detector.
- framebuffer_scanout instantiates vga_timing_counter and adds address generation, the delay line and output registers.

Test Plan:
- Reset release:
  - While reset_n = 0: hsync = vsync = 1, de = 0, pixel = 0, fb_read_addr = 0.
  - First de rise exactly 3 clocks after release, together with frame_start = 1.
- Line 0 addressing: fb_read_addr sequence 0,0,0,0,1,1,1,1,...,159 over h = 0..639. Lines 0..3 repeat 0..159; line 4 starts at 160; line 479 ends at 19199.
- Data alignment:
  - Framebuffer model returns q = read_addr[0] one clock after the address.
  - vga_pixel shows 4-clock alternating runs 0000 1111 ..., with no skew relative to de.
- Horizontal timing, per line:
  - de high 640 clocks.
  - hsync low 96 clocks starting 16 clocks after de falls.
  - Line period 800 clocks.
- Vertical timing:
  - vsync low for exactly 2 lines (1600 clocks) starting 10 lines after the last active line.
  - frame_start period 420000 clocks.
  - Address returns to 0 on the next frame.
- Reset mid-frame:
  - Assert reset_n = 0 at h=300, v=200; all outputs go to reset values asynchronously.
  - On release, timing restarts at (0,0) with fb_read_addr = 0 and no spurious sync pulses.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants for the scanout path and any other
// block that needs to follow the display raster.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

  // Sync windows are [start, end) in counter units.
  localparam int H_SYNC_START = H_ACTIVE + H_FP;               // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;         // 752
  localparam int V_SYNC_START = V_ACTIVE + V_FP;               // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;         // 492

  // Counter state -> read address -> framebuffer q -> pins.
  localparam int PIPE_LATENCY = 3;

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port plus the VGA pin bundle driven by the scanout block.
interface framebuffer_scanout_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] fb_read_addr;
  logic [DATA_WIDTH-1:0] fb_q;
  logic                  vga_hsync;
  logic                  vga_vsync;
  logic                  vga_de;
  logic [DATA_WIDTH-1:0] vga_pixel;
  logic                  frame_start;

  // Scanout side: issues reads, consumes q, drives pins.
  modport master (
    output fb_read_addr, vga_hsync, vga_vsync, vga_de, vga_pixel, frame_start,
    input  fb_q
  );

  // Framebuffer / pin side.
  modport slave (
    input  fb_read_addr, vga_hsync, vga_vsync, vga_de, vga_pixel, frame_start,
    output fb_q
  );
endinterface

// File: rtl/vga_timing_counter.sv
// Free-running raster counters with visible-region and sync decode.
// Outputs are the raw stage-0 view; callers add their own pipeline delay.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic          active,
  output logic          hs_n,
  output logic          vs_n,
  output logic          line_last,
  output logic          frame_last
);

  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_END    = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_END    = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  assign line_last  = (h_count == H_END);
  assign frame_last = line_last && (v_count == V_END);

  // h wraps every line; v steps on the h wrap and wraps with it at frame end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (line_last) begin
      h_count <= '0;
      v_count <= frame_last ? '0 : v_count + VW'(1);
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  // Region and active-low sync decode on the current counter state.
  always_comb begin
    active = (h_count < H_VIS) && (v_count < V_VIS);
    hs_n   = !((h_count >= HS_START) && (h_count < HS_END));
    vs_n   = !((v_count >= VS_START) && (v_count < VS_END));
  end

endmodule

// File: rtl/framebuffer_scanout.sv
// VGA scanout of a low-res framebuffer with integer pixel replication.
// Read addresses are built incrementally (no multiplier) and every pin is
// delayed to line up with the framebuffer's one-clock registered read.
module framebuffer_scanout
  import vga_timing_pkg::*;
#(
  parameter int DATA_WIDTH  = 1,
  parameter int ADDR_WIDTH  = 15,
  parameter int FB_WIDTH    = 160,
  parameter int FB_HEIGHT   = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP
) (
  input  logic                  clock,
  input  logic                  reset_n,
  framebuffer_scanout_if.master bus
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int PL = PIPE_LATENCY;
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_WIDTH);
  localparam logic [VW-1:0]         LAST_ROW = VW'(FB_HEIGHT - 1);

  logic [HW-1:0]         h_count;
  logic [VW-1:0]         v_count;
  logic                  active, hs_n, vs_n, line_last, frame_last;
  logic                  at_origin, row_done, row_more;
  logic [ADDR_WIDTH-1:0] line_base, h_col, fb_read_addr;
  logic [DATA_WIDTH-1:0] vga_pixel;
  logic [PL:1]           act_pipe, hs_pipe, vs_pipe, fs_pipe;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW (HW), .VW (VW)
  ) u_timing (
    .clock      (clock),
    .reset_n    (reset_n),
    .h_count    (h_count),
    .v_count    (v_count),
    .active     (active),
    .hs_n       (hs_n),
    .vs_n       (vs_n),
    .line_last  (line_last),
    .frame_last (frame_last)
  );

  assign at_origin = (h_count == '0) && (v_count == '0);
  // Last display line of a replicated group, and more source rows remain.
  // The bottom source row never advances, so blanking reads stay in range.
  assign row_done  = &v_count[SCALE_SHIFT-1:0];
  assign row_more  = (v_count >> SCALE_SHIFT) < LAST_ROW;
  assign h_col     = ADDR_WIDTH'(h_count >> SCALE_SHIFT);

  // Row base address advanced by one source row per 2^SCALE_SHIFT lines.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_base <= '0;
    end else if (line_last) begin
      if (frame_last)
        line_base <= '0;
      else if (row_done && row_more)
        line_base <= line_base + ROW_STEP;
    end
  end

  // Stage 1: read address; column offset only inside the visible window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      fb_read_addr <= '0;
    else
      fb_read_addr <= active ? line_base + h_col : line_base;
  end

  // Delay line carrying control for the same (h,v) as the data to the pins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      fs_pipe  <= '0;
    end else begin
      act_pipe <= {act_pipe[PL-1:1], active};
      hs_pipe  <= {hs_pipe[PL-1:1],  hs_n};
      vs_pipe  <= {vs_pipe[PL-1:1],  vs_n};
      fs_pipe  <= {fs_pipe[PL-1:1],  at_origin};
    end
  end

  // Pixel register; q is blanked outside the visible window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      vga_pixel <= '0;
    else
      vga_pixel <= act_pipe[PL-1] ? bus.fb_q : '0;
  end

  assign bus.fb_read_addr = fb_read_addr;
  assign bus.vga_hsync    = hs_pipe[PL];
  assign bus.vga_vsync    = vs_pipe[PL];
  assign bus.vga_de       = act_pipe[PL];
  assign bus.vga_pixel    = vga_pixel;
  assign bus.frame_start  = fs_pipe[PL];

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: one full-size 640x480 instance (first lines
// only) and one shrunken-raster instance run over several whole frames.
// Both are compared each clock against a raster-position reference model.
module tb_framebuffer_scanout;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  framebuffer_scanout_if #(.DATA_WIDTH(1), .ADDR_WIDTH(15)) if_f ();
  framebuffer_scanout_if #(.DATA_WIDTH(1), .ADDR_WIDTH(8))  if_s ();

  framebuffer_scanout dut_f (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_f)
  );

  // 16x12 source, 64x48 visible, 80x55 total -> 4400 clocks per frame.
  framebuffer_scanout #(
    .DATA_WIDTH (1), .ADDR_WIDTH (8), .FB_WIDTH (16), .FB_HEIGHT (12),
    .SCALE_SHIFT(2),
    .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (48), .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) dut_s (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_s)
  );

  bit mem_f [19200];
  bit mem_s [192];

  // Framebuffer models: one-clock registered read.
  always @(posedge clock) begin
    if_f.fb_q <= mem_f[if_f.fb_read_addr];
    if_s.fb_q <= mem_s[if_s.fb_read_addr];
  end

  typedef struct packed {
    logic        hs, vs, de, fs;
    int unsigned pix_a;
    int unsigned rd_a;
  } exp_t;

  int n_cmp, n_bad, k, last_fs;

  // k = clock edges since reset release. Pins after edge k show raster
  // position k-3; the read address after edge k belongs to position k-1.
  function automatic exp_t model(int kk, int ha, int hfp, int hsy, int hbp,
                                 int va, int vfp, int vsy, int vbp,
                                 int fbw, int fbh, int sh);
    exp_t e;
    int ht, vt, p, h, v, r;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (kk >= 3) begin
      p = kk - 3; h = p % ht; v = (p / ht) % vt;
      e.de = (h < ha) && (v < va);
      e.hs = !((h >= ha + hfp) && (h < ha + hfp + hsy));
      e.vs = !((v >= va + vfp) && (v < va + vfp + vsy));
      e.fs = (h == 0) && (v == 0);
      e.pix_a = e.de ? (v >> sh) * fbw + (h >> sh) : 0;
    end
    if (kk >= 1) begin
      p = kk - 1; h = p % ht; v = (p / ht) % vt;
      r = v >> sh;
      if (r > fbh - 1) r = fbh - 1;
      e.rd_a = r * fbw + (((h < ha) && (v < va)) ? (h >> sh) : 0);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
      else begin
        n_bad++;
        $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, obs, exp_v);
      end
  endtask

  task automatic check_all();
    exp_t ef, es;
    ef = model(k, 640, 16, 96, 48, 480, 10, 2, 33, 160, 120, 2);
    es = model(k, 64, 4, 8, 4, 48, 2, 2, 3, 16, 12, 2);
    chk("f_hsync", 32'(if_f.vga_hsync),    32'(ef.hs));
    chk("f_vsync", 32'(if_f.vga_vsync),    32'(ef.vs));
    chk("f_de",    32'(if_f.vga_de),       32'(ef.de));
    chk("f_fs",    32'(if_f.frame_start),  32'(ef.fs));
    chk("f_pixel", 32'(if_f.vga_pixel),    ef.de ? 32'(mem_f[15'(ef.pix_a)]) : 32'd0);
    chk("f_addr",  32'(if_f.fb_read_addr), ef.rd_a);
    chk("s_hsync", 32'(if_s.vga_hsync),    32'(es.hs));
    chk("s_vsync", 32'(if_s.vga_vsync),    32'(es.vs));
    chk("s_de",    32'(if_s.vga_de),       32'(es.de));
    chk("s_fs",    32'(if_s.frame_start),  32'(es.fs));
    chk("s_pixel", 32'(if_s.vga_pixel),    es.de ? 32'(mem_s[8'(es.pix_a)]) : 32'd0);
    chk("s_addr",  32'(if_s.fb_read_addr), es.rd_a);
    if (if_s.frame_start === 1'b1) begin
      if (last_fs >= 0) chk("s_fs_period", 32'(k - last_fs), 32'd4400);
      last_fs = k;
    end
  endtask

  // Clock with reset held: everything must sit at reset values.
  task automatic hold_reset(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      @(negedge clock);
      check_all();
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      k++;
      @(negedge clock);
      check_all();
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; k = 0; last_fs = -1;
    for (int i = 0; i < 19200; i++) mem_f[15'(i)] = i[0];
    for (int i = 0; i < 192; i++)   mem_s[8'(i)] = 1'($urandom);

    // Power-on reset, released between edges.
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    hold_reset($urandom_range(3, 8));
    reset_n = 1'b1;

    // Four small frames plus a bit; full-size instance covers its first lines.
    run(18000);

    // Reach raster (30,20) of the small instance, then reset between edges.
    run((1630 + 4400 - (k % 4400)) % 4400);
    #2 reset_n = 1'b0;
    k = 0;
    last_fs = -1;
    #1 check_all();
    hold_reset($urandom_range(2, 6));
    reset_n = 1'b1;

    // Restart from (0,0): two more small frames.
    run(9500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
